// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: ALU op classes, the bubble
// encoding and the packed control bundle carried from decode into execute.
package id_ex_stage_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        U_TYPE = 3'd5,
        JUMP   = 3'd6,
        NOP    = 3'd7
    } aluop_e;

    localparam aluop_e BUBBLE_ALUOP = NOP;

    typedef struct packed {
        aluop_e     aluop;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        aluop:     BUBBLE_ALUOP,
        funct3:    3'd0,
        funct7:    7'd0,
        rs1:       5'd0,
        rs2:       5'd0,
        rd:        5'd0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_src:   1'b0
    };

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use detector: a load sitting in EX whose destination is read by the
// instruction in ID forces a one-cycle stall, unless EX is being flushed.
module hazard_unit (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_flush,
    output logic       hazard_stall
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it has no consumer to stall.
    assign ex_is_load   = ex_valid & ex_mem_read & (ex_rd != 5'd0);
    assign rs1_hit      = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit      = id_uses_rs2 & (id_rs2 == ex_rd);
    assign hazard_stall = ex_is_load & id_valid & (rs1_hit | rs2_hit) & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and
// saturating bubble/flush performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_aluop,
    input  logic [2:0]       id_funct3,
    input  logic [6:0]       id_funct7,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic [2:0]       ex_aluop,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_ctrl_t          ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
    logic [XLEN-1:0]   imm_d, imm_q;
    logic [XLEN-1:0]   pc_d, pc_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_unit u_hazard (
        .ex_valid     (valid_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_rd        (ctrl_q.rd),
        .id_valid     (id_valid),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_flush     (ex_flush),
        .hazard_stall (hazard_stall)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ctrl_d       = BUBBLE_CTRL;
        valid_d      = 1'b0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        pc_d         = '0;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        // Flush outranks the stall; both load the bubble defaults above.
        if (ex_flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hazard_stall) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (id_valid) begin
            valid_d          = 1'b1;
            ctrl_d.aluop     = aluop_e'(id_aluop);
            ctrl_d.funct3    = id_funct3;
            ctrl_d.funct7    = id_funct7;
            ctrl_d.rs1       = id_rs1;
            ctrl_d.rs2       = id_rs2;
            ctrl_d.rd        = id_rd;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            ctrl_d.mem_write = id_mem_write;
            ctrl_d.alu_src   = id_alu_src;
            rs1_data_d       = id_rs1_data;
            rs2_data_d       = id_rs2_data;
            imm_d            = id_imm;
            pc_d             = id_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= BUBBLE_CTRL;
            valid_q      <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_aluop     = ctrl_q.aluop;
    assign ex_funct3    = ctrl_q.funct3;
    assign ex_funct7    = ctrl_q.funct7;
    assign ex_rs1       = ctrl_q.rs1;
    assign ex_rs2       = ctrl_q.rs2;
    assign ex_rd        = ctrl_q.rd;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/saturation/reset
// scenarios followed by randomized traffic against a transaction-level model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic            valid;
        logic [2:0]      aluop;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } instr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_flush;
    instr_t          id_in;

    logic             ex_valid;
    logic [2:0]       ex_aluop;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_alu_src;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_pc;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    instr_t exp_ex;
    int     exp_bub;
    int     exp_fl;
    int     n_cmp = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_in.valid),
        .id_aluop     (id_in.aluop),
        .id_funct3    (id_in.funct3),
        .id_funct7    (id_in.funct7),
        .id_rs1       (id_in.rs1),
        .id_rs2       (id_in.rs2),
        .id_rd        (id_in.rd),
        .id_uses_rs1  (id_in.uses_rs1),
        .id_uses_rs2  (id_in.uses_rs2),
        .id_reg_write (id_in.reg_write),
        .id_mem_read  (id_in.mem_read),
        .id_mem_write (id_in.mem_write),
        .id_alu_src   (id_in.alu_src),
        .id_rs1_data  (id_in.rs1_data),
        .id_rs2_data  (id_in.rs2_data),
        .id_imm       (id_in.imm),
        .id_pc        (id_in.pc),
        .ex_flush     (ex_flush),
        .ex_valid     (ex_valid),
        .ex_aluop     (ex_aluop),
        .ex_funct3    (ex_funct3),
        .ex_funct7    (ex_funct7),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_src   (ex_alu_src),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_pc        (ex_pc),
        .hazard_stall (hazard_stall),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t bubble_instr();
        instr_t b;
        b = '{default: '0};
        b.aluop = BUBBLE_ALUOP;
        return b;
    endfunction

    function automatic instr_t make_instr(input logic v, input aluop_e op, input int rd,
                                          input int rs1, input int rs2, input logic u1,
                                          input logic u2, input logic rw, input logic mr,
                                          input logic mw, input logic as);
        instr_t t;
        t.valid     = v;
        t.aluop     = op;
        t.funct3    = 3'($urandom);
        t.funct7    = 7'($urandom);
        t.rd        = 5'(rd);
        t.rs1       = 5'(rs1);
        t.rs2       = 5'(rs2);
        t.uses_rs1  = u1;
        t.uses_rs2  = u2;
        t.reg_write = rw;
        t.mem_read  = mr;
        t.mem_write = mw;
        t.alu_src   = as;
        t.rs1_data  = $urandom;
        t.rs2_data  = $urandom;
        t.imm       = $urandom;
        t.pc        = $urandom;
        return t;
    endfunction

    // Load-use rule evaluated on the model's view of EX and the current ID inputs.
    function automatic logic model_hazard();
        logic load_in_ex;
        logic uses_rd;
        load_in_ex = exp_ex.valid && exp_ex.mem_read && (exp_ex.rd != 5'd0);
        uses_rd    = (id_in.uses_rs1 && id_in.rs1 == exp_ex.rd) ||
                     (id_in.uses_rs2 && id_in.rs2 == exp_ex.rd);
        return load_in_ex && id_in.valid && uses_rd && !ex_flush;
    endfunction

    task automatic model_reset();
        exp_ex  = bubble_instr();
        exp_bub = 0;
        exp_fl  = 0;
    endtask

    task automatic check_ex(input string tag);
        check({tag, ".valid"}, ex_valid, exp_ex.valid);
        check({tag, ".aluop"}, ex_aluop, exp_ex.aluop);
        check({tag, ".ctrl"},
              {ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src},
              {exp_ex.funct3, exp_ex.funct7, exp_ex.rs1, exp_ex.rs2, exp_ex.rd,
               exp_ex.reg_write, exp_ex.mem_read, exp_ex.mem_write, exp_ex.alu_src});
        check({tag, ".rs1_data"}, ex_rs1_data, exp_ex.rs1_data);
        check({tag, ".rs2_data"}, ex_rs2_data, exp_ex.rs2_data);
        check({tag, ".imm"}, ex_imm, exp_ex.imm);
        check({tag, ".pc"}, ex_pc, exp_ex.pc);
        check({tag, ".bubble_cnt"}, bubble_cnt, 64'(exp_bub));
        check({tag, ".flush_cnt"}, flush_cnt, 64'(exp_fl));
    endtask

    // One clock: check the combinational stall, advance the model, check EX.
    task automatic step(input string tag);
        logic exp_stall;
        #1;
        exp_stall = model_hazard();
        check({tag, ".stall"}, hazard_stall, exp_stall);
        @(posedge clk);
        if (ex_flush) begin
            exp_ex = bubble_instr();
            if (exp_fl < CNT_MAX) exp_fl++;
        end else if (exp_stall) begin
            exp_ex = bubble_instr();
            if (exp_bub < CNT_MAX) exp_bub++;
        end else if (id_in.valid) begin
            exp_ex = id_in;
        end else begin
            exp_ex = bubble_instr();
        end
        #1;
        check_ex(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        ex_flush = 1'b0;
        id_in    = bubble_instr();
        model_reset();

        // Reset holds EX in bubble state whatever decode presents.
        for (int i = 0; i < 4; i++) begin
            id_in    = make_instr(1'b1, LOAD, 5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            ex_flush = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst.valid", ex_valid, 1'b0);
            check("rst.aluop", ex_aluop, NOP);
            check("rst.bubble_cnt", bubble_cnt, 0);
            check("rst.flush_cnt", flush_cnt, 0);
            check("rst.stall", hazard_stall, 1'b0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        ex_flush = 1'b0;

        // ADD x3,x1,x2
        id_in = make_instr(1'b1, R_TYPE, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("add");
        check("add.aluop_lit", ex_aluop, R_TYPE);
        check("add.rd_lit", ex_rd, 5'd3);

        // LW x5 then ADD x6,x5,x1: one bubble, then the ADD proceeds.
        id_in = make_instr(1'b1, LOAD, 5, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw5");
        id_in = make_instr(1'b1, R_TYPE, 6, 5, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("lu.stall_lit", hazard_stall, 1'b1);
        step("lu.bubble");
        check("lu.bubble_valid_lit", ex_valid, 1'b0);
        #1 check("lu.stall_clear_lit", hazard_stall, 1'b0);
        step("lu.capture");
        check("lu.rd_lit", ex_rd, 5'd6);
        check("lu.bubble_cnt_lit", bubble_cnt, 1);

        // LW x0 followed by a reader of x0: no stall.
        id_in = make_instr(1'b1, LOAD, 0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw0");
        id_in = make_instr(1'b1, R_TYPE, 6, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("x0.stall_lit", hazard_stall, 1'b0);
        step("x0.use");

        // LW x5 followed by LUI x5, which reads no sources: no stall.
        id_in = make_instr(1'b1, LOAD, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw5b");
        id_in = make_instr(1'b1, U_TYPE, 5, 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("lui.stall_lit", hazard_stall, 1'b0);
        step("lui");

        // Flush with a valid BEQ in ID.
        id_in    = make_instr(1'b1, BRANCH, 0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_flush = 1'b1;
        step("flush");
        check("flush.valid_lit", ex_valid, 1'b0);
        check("flush.cnt_lit", flush_cnt, 1);
        ex_flush = 1'b0;

        // Flush coincident with a load-use hazard: flush wins.
        id_in = make_instr(1'b1, LOAD, 5, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("fh.lw");
        id_in    = make_instr(1'b1, R_TYPE, 6, 5, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_flush = 1'b1;
        #1 check("fh.stall_lit", hazard_stall, 1'b0);
        step("fh.flush");
        check("fh.bubble_cnt_lit", bubble_cnt, 1);
        check("fh.flush_cnt_lit", flush_cnt, 2);
        ex_flush = 1'b0;

        // 20 load-use pairs saturate the 4-bit bubble counter.
        for (int i = 0; i < 20; i++) begin
            id_in = make_instr(1'b1, LOAD, 7, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            step("sat.lw");
            id_in = make_instr(1'b1, R_TYPE, 8, 7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step("sat.stall");
            step("sat.capture");
        end
        check("sat.bubble_cnt_lit", bubble_cnt, 15);

        // Asynchronous reset between edges while EX holds a real instruction.
        id_in = make_instr(1'b1, LOAD, 9, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("ar.pre");
        check("ar.pre_valid_lit", ex_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid", ex_valid, 1'b0);
        check("ar.aluop", ex_aluop, NOP);
        check("ar.mem_read", ex_mem_read, 1'b0);
        check("ar.bubble_cnt", bubble_cnt, 0);
        check("ar.flush_cnt", flush_cnt, 0);
        check("ar.stall", hazard_stall, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            id_in = make_instr($urandom_range(0, 3) != 0, aluop_e'($urandom_range(0, 7)),
                               $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            ex_flush = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
